// File: rtl/mii_pkg.sv
// Shared types and constants for the MII test-path frame scheduler.
package mii_pkg;

  localparam int ADDR_W = 42;
  localparam int TYPE_W = 16;
  localparam int INT_W  = 8;

  localparam logic [INT_W-1:0] STOP_TX   = 8'h01;
  localparam logic [INT_W-1:0] STOP_DATA = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    START,
    BUSY,
    GAP,
    END
  } sched_state_t;

  typedef struct packed {
    logic              fixed_flag;
    logic [INT_W-1:0]  interrupt;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W-1:0] src_addr;
    logic [TYPE_W-1:0] frame_type;
    logic [TYPE_W-1:0] opcode;
  } frame_cfg_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req at or after ptr, wrapping; one-hot grant.
// Latency: combinational.
// Backpressure: none; the caller decides when to accept the pick.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  localparam logic [IDX_W:0] N_L = (IDX_W+1)'(N);

  logic [IDX_W:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    vld   = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + (IDX_W+1)'(i);
      if (pos >= N_L) pos = pos - N_L;
      if (!vld && req[pos[IDX_W-1:0]]) begin
        vld = 1'b1;
        idx = pos[IDX_W-1:0];
      end
    end
    grant[idx] = vld;
  end

endmodule

// File: rtl/mac_frame_scheduler.sv
// Shares the MAC frame generator among N_REQ requesters with round-robin bursts.
// Latency: req seen in IDLE at cycle k -> o_start at k+2; frames FRAME+IPG+1 apart.
// Backpressure: none; i_enable low lets the current frame finish then ends the burst. SCHED_STATS_EN adds counters.
module mac_frame_scheduler
  import mii_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int FRAME_CYCLES = 10,
  parameter int IPG_CYCLES   = 3,
  parameter int BURST_W      = 8
) (
  input  logic                      clk,
  input  logic                      i_rst_n,
  input  logic                      i_enable,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*BURST_W-1:0]  i_burst_len,
  input  logic [N_REQ-1:0]          i_fixed_flag,
  input  logic [N_REQ*INT_W-1:0]    i_interrupt,
  input  logic [N_REQ*ADDR_W-1:0]   i_dst_addr,
  input  logic [N_REQ*ADDR_W-1:0]   i_src_addr,
  input  logic [N_REQ*TYPE_W-1:0]   i_type,
  input  logic [N_REQ*TYPE_W-1:0]   i_opcode,
  output logic [N_REQ-1:0]          o_grant,
  output logic [N_REQ-1:0]          o_done,
  output logic                      o_busy,
  output logic                      o_start,
  output logic                      o_fixed_flag,
  output logic [INT_W-1:0]          o_interrupt,
  output logic [ADDR_W-1:0]         o_dst_addr,
  output logic [ADDR_W-1:0]         o_src_addr,
  output logic [TYPE_W-1:0]         o_type,
  output logic [TYPE_W-1:0]         o_opcode
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]               o_frame_cnt,
  output logic [31:0]               o_burst_cnt
`endif
);

  localparam int IDX_W   = $clog2(N_REQ);
  localparam int CNT_MAX = max_int(FRAME_CYCLES, IPG_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // START counts as the first busy cycle, so BUSY itself runs FRAME_CYCLES-1 cycles.
  localparam logic [CNT_W-1:0] BUSY_LD = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0);

  sched_state_t state, state_nxt;

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   arb_idx;
  logic [N_REQ-1:0]   arb_gnt;
  logic               arb_vld;
  logic [CNT_W-1:0]   cyc_cnt;
  logic [BURST_W-1:0] burst_cnt;
  logic [BURST_W-1:0] burst_sel;
  frame_cfg_t         cfg_sel;
  frame_cfg_t         cfg_q;
  logic [N_REQ-1:0]   grant_q;
  logic [N_REQ-1:0]   done_q;
  logic               arb_take;
  logic               burst_fin;
  logic               busy_last;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (i_req),
    .ptr   (rr_ptr),
    .grant (arb_gnt),
    .idx   (arb_idx),
    .vld   (arb_vld)
  );

  always_comb begin
    cfg_sel   = '0;
    burst_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        cfg_sel.fixed_flag = i_fixed_flag[i];
        cfg_sel.interrupt  = i_interrupt[i*INT_W +: INT_W];
        cfg_sel.dst_addr   = i_dst_addr[i*ADDR_W +: ADDR_W];
        cfg_sel.src_addr   = i_src_addr[i*ADDR_W +: ADDR_W];
        cfg_sel.frame_type = i_type[i*TYPE_W +: TYPE_W];
        cfg_sel.opcode     = i_opcode[i*TYPE_W +: TYPE_W];
        burst_sel          = i_burst_len[i*BURST_W +: BURST_W];
      end
    end
  end

  assign busy_last = (cyc_cnt <= CNT_W'(1));

  always_comb begin
    state_nxt = state;
    arb_take  = 1'b0;
    burst_fin = 1'b0;
    case (state)
      IDLE:  if (i_enable && |i_req) state_nxt = ARB;
      ARB: begin
        if (arb_vld) begin
          arb_take  = 1'b1;
          state_nxt = START;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: state_nxt = BUSY;
      BUSY:  if (busy_last) state_nxt = (IPG_CYCLES > 0) ? GAP : END;
      GAP:   if (cyc_cnt == '0) state_nxt = END;
      END: begin
        if ((burst_cnt > BURST_W'(1)) && i_enable) begin
          state_nxt = START;
        end else begin
          burst_fin = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr    <= '0;
      win_idx   <= '0;
      cyc_cnt   <= '0;
      burst_cnt <= '0;
      cfg_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
    end else begin
      done_q <= '0;
      if (arb_take) begin
        grant_q   <= arb_gnt;
        win_idx   <= arb_idx;
        cfg_q     <= cfg_sel;
        // A zero length still means one frame.
        burst_cnt <= (burst_sel == '0) ? BURST_W'(1) : burst_sel;
      end
      case (state)
        START: cyc_cnt <= BUSY_LD;
        BUSY:  cyc_cnt <= busy_last ? GAP_LD : cyc_cnt - 1'b1;
        GAP:   if (cyc_cnt != '0) cyc_cnt <= cyc_cnt - 1'b1;
        END: begin
          if (burst_fin) begin
            done_q  <= grant_q;
            grant_q <= '0;
            rr_ptr  <= (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
          end else begin
            burst_cnt <= burst_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SCHED_STATS_EN
  logic [31:0] frame_cnt_q;
  logic [31:0] burst_cnt_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt_q <= '0;
      burst_cnt_q <= '0;
    end else begin
      if (state == START) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (burst_fin)      burst_cnt_q <= burst_cnt_q + 1'b1;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
  assign o_burst_cnt = burst_cnt_q;
`endif

  // o_start decodes the state register so an async reset removes it at once.
  assign o_start      = (state == START);
  assign o_busy       = (state != IDLE);
  assign o_grant      = grant_q;
  assign o_done       = done_q;
  assign o_fixed_flag = cfg_q.fixed_flag;
  assign o_interrupt  = cfg_q.interrupt;
  assign o_dst_addr   = cfg_q.dst_addr;
  assign o_src_addr   = cfg_q.src_addr;
  assign o_type       = cfg_q.frame_type;
  assign o_opcode     = cfg_q.opcode;

endmodule

// File: tb/tb_mac_frame_scheduler.sv
// Bench for mac_frame_scheduler: event-time reference model of bursts, starts and done pulses.
`timescale 1ns/1ps
module tb_mac_frame_scheduler;
  import mii_pkg::*;

  localparam int N   = 4;
  localparam int FR  = 10;
  localparam int IPG = 3;
  localparam int BW  = 8;
  localparam int P   = FR + IPG + 1;
  localparam int CW  = 1 + 8 + 42 + 42 + 16 + 16;
  localparam int NEVER = 1 << 30;

  logic              clk = 1'b0;
  logic              i_rst_n;
  logic              i_enable;
  logic [N-1:0]      i_req;
  logic [N*BW-1:0]   i_burst_len;
  logic [N-1:0]      i_fixed_flag;
  logic [N*8-1:0]    i_interrupt;
  logic [N*42-1:0]   i_dst_addr;
  logic [N*42-1:0]   i_src_addr;
  logic [N*16-1:0]   i_type;
  logic [N*16-1:0]   i_opcode;
  logic [N-1:0]      o_grant;
  logic [N-1:0]      o_done;
  logic              o_busy;
  logic              o_start;
  logic              o_fixed_flag;
  logic [7:0]        o_interrupt;
  logic [41:0]       o_dst_addr;
  logic [41:0]       o_src_addr;
  logic [15:0]       o_type;
  logic [15:0]       o_opcode;
`ifdef SCHED_STATS_EN
  logic [31:0]       o_frame_cnt;
  logic [31:0]       o_burst_cnt;
`endif

  mac_frame_scheduler #(.N_REQ(N), .FRAME_CYCLES(FR), .IPG_CYCLES(IPG), .BURST_W(BW)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_req(i_req),
    .i_burst_len(i_burst_len), .i_fixed_flag(i_fixed_flag), .i_interrupt(i_interrupt),
    .i_dst_addr(i_dst_addr), .i_src_addr(i_src_addr), .i_type(i_type), .i_opcode(i_opcode),
    .o_grant(o_grant), .o_done(o_done), .o_busy(o_busy), .o_start(o_start),
    .o_fixed_flag(o_fixed_flag), .o_interrupt(o_interrupt), .o_dst_addr(o_dst_addr),
    .o_src_addr(o_src_addr), .o_type(o_type), .o_opcode(o_opcode)
`ifdef SCHED_STATS_EN
    , .o_frame_cnt(o_frame_cnt), .o_burst_cnt(o_burst_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;

  logic [7:0]  cur_blen [N];
  logic        cur_fix  [N];
  logic [7:0]  cur_int  [N];
  logic [41:0] cur_dst  [N];
  logic [41:0] cur_src  [N];
  logic [15:0] cur_typ  [N];
  logic [15:0] cur_opc  [N];

  int          got_s_cyc[$], exp_s_cyc[$], got_d_cyc[$], exp_d_cyc[$];
  logic [3:0]  got_s_gnt[$], exp_s_gnt[$], got_d_val[$], exp_d_val[$];
  logic [CW-1:0] got_s_cfg[$], exp_s_cfg[$];

  always @(negedge clk) begin
    if (i_rst_n) begin
      if (o_start) begin
        got_s_cyc.push_back(cyc);
        got_s_gnt.push_back(o_grant);
        got_s_cfg.push_back({o_fixed_flag, o_interrupt, o_dst_addr, o_src_addr, o_type, o_opcode});
      end
      if (|o_done) begin
        got_d_cyc.push_back(cyc);
        got_d_val.push_back(o_done);
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] cfg_of(input int w);
    return {cur_fix[w], cur_int[w], cur_dst[w], cur_src[w], cur_typ[w], cur_opc[w]};
  endfunction

  task automatic drive_cfg();
    for (int i = 0; i < N; i++) begin
      i_burst_len[i*BW +: BW] = cur_blen[i];
      i_fixed_flag[i]         = cur_fix[i];
      i_interrupt[i*8 +: 8]   = cur_int[i];
      i_dst_addr[i*42 +: 42]  = cur_dst[i];
      i_src_addr[i*42 +: 42]  = cur_src[i];
      i_type[i*16 +: 16]      = cur_typ[i];
      i_opcode[i*16 +: 16]    = cur_opc[i];
    end
  endtask

  task automatic clear_q();
    got_s_cyc.delete(); got_s_gnt.delete(); got_s_cfg.delete();
    got_d_cyc.delete(); got_d_val.delete();
    exp_s_cyc.delete(); exp_s_gnt.delete(); exp_s_cfg.delete();
    exp_d_cyc.delete(); exp_d_val.delete();
  endtask

  // One burst seen from the IDLE cycle t0 that samples the request; td = first cycle enable is low.
  task automatic model_burst(input int t0, input logic [3:0] req, input int td, output int done_cyc);
    int w, n, s, last_s, c;
    w = -1;
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (w < 0 && req[c]) w = c;
    end
    n = (cur_blen[w] == 0) ? 1 : int'(cur_blen[w]);
    last_s = t0 + 2;
    for (int f = 0; f < n; f++) begin
      s = t0 + 2 + f * P;
      exp_s_cyc.push_back(s);
      exp_s_gnt.push_back(4'(1 << w));
      exp_s_cfg.push_back(cfg_of(w));
      last_s = s;
      if (s + P - 1 >= td) break;
    end
    done_cyc = last_s + P;
    exp_d_cyc.push_back(done_cyc);
    exp_d_val.push_back(4'(1 << w));
    m_ptr = (w + 1) % N;
  endtask

  task automatic collect(input string tag, input int deadline);
    int ns, nd;
    while (cyc < deadline) step();
    chk({tag, "_nstart"}, got_s_cyc.size(), exp_s_cyc.size());
    ns = (got_s_cyc.size() < exp_s_cyc.size()) ? got_s_cyc.size() : exp_s_cyc.size();
    for (int i = 0; i < ns; i++) begin
      chk($sformatf("%s_scyc%0d", tag, i), got_s_cyc[i], exp_s_cyc[i]);
      chk($sformatf("%s_sgnt%0d", tag, i), got_s_gnt[i], exp_s_gnt[i]);
      chk($sformatf("%s_scfg%0d", tag, i), got_s_cfg[i], exp_s_cfg[i]);
    end
    chk({tag, "_ndone"}, got_d_cyc.size(), exp_d_cyc.size());
    nd = (got_d_cyc.size() < exp_d_cyc.size()) ? got_d_cyc.size() : exp_d_cyc.size();
    for (int i = 0; i < nd; i++) begin
      chk($sformatf("%s_dcyc%0d", tag, i), got_d_cyc[i], exp_d_cyc[i]);
      chk($sformatf("%s_dval%0d", tag, i), got_d_val[i], exp_d_val[i]);
    end
    chk({tag, "_idle"}, {o_busy, o_grant}, 0);
    clear_q();
  endtask

  // Static config and request for nb back-to-back bursts; request dropped at the first or last start.
  task automatic run_static(input string tag, input logic [3:0] req, input int nb, input bit early);
    int t, d, stop_at;
    t = cyc;
    d = t;
    i_req = req;
    for (int b = 0; b < nb; b++) begin
      model_burst(t, req, NEVER, d);
      t = d;
    end
    stop_at = early ? exp_s_cyc[0] : exp_s_cyc[$];
    while (cyc < stop_at) step();
    i_req = '0;
    collect(tag, d + 6);
  endtask

  task automatic do_reset(input string tag);
    i_req   = '0;
    i_rst_n = 1'b0;
    #1;
    chk({tag, "_ctl"}, {o_start, o_busy, o_grant, o_done}, 0);
    chk({tag, "_cfg"}, {o_fixed_flag, o_interrupt, o_dst_addr, o_src_addr, o_type, o_opcode}, 0);
`ifdef SCHED_STATS_EN
    chk({tag, "_stats"}, {o_frame_cnt, o_burst_cnt}, 0);
`endif
    repeat (3) step();
    i_rst_n = 1'b1;
    m_ptr   = 0;
    clear_q();
    step();
    step();
    chk({tag, "_busy"}, o_busy, 0);
  endtask

  initial begin
    int t0, d1, d2, td;
    logic [41:0] old_dst;

    i_rst_n = 1'b0; i_enable = 1'b1; i_req = '0;
    for (int i = 0; i < N; i++) begin
      cur_blen[i] = 8'd1;
      cur_fix[i]  = i[0];
      cur_int[i]  = STOP_TX;
      cur_dst[i]  = 42'h0A0B0C0D0E0 + 42'(i);
      cur_src[i]  = 42'h155443322 + 42'(i << 8);
      cur_typ[i]  = 16'h0800 + 16'(i);
      cur_opc[i]  = 16'h0001 + 16'(i << 4);
    end
    drive_cfg();
    step();
    do_reset("t1_rst");

    cur_blen[0] = 8'd3;
    cur_int[0]  = STOP_DATA;
    drive_cfg();
    step();
    run_static("t2_burst3", 4'b0001, 1, 1'b1);

    do_reset("t3_rst");
    for (int i = 0; i < N; i++) cur_blen[i] = 8'd1;
    drive_cfg();
    step();
    run_static("t3_rr", 4'b1111, 5, 1'b0);

    cur_blen[1] = 8'd5;
    drive_cfg();
    step();
    t0 = cyc;
    i_req = 4'b0010;
    td = t0 + 2 + P + 2;
    model_burst(t0, 4'b0010, td, d1);
    while (cyc < td) step();
    i_enable = 1'b0;
    collect("t4_enable", d1 + 30);
    i_req = '0;
    i_enable = 1'b1;
    step();

    cur_blen[0] = 8'd2;
    cur_dst[0]  = 42'h123456789A;
    old_dst     = cur_dst[0];
    drive_cfg();
    step();
    t0 = cyc;
    i_req = 4'b0001;
    model_burst(t0, 4'b0001, NEVER, d1);
    cur_dst[0] = ~old_dst;
    model_burst(d1, 4'b0001, NEVER, d2);
    while (cyc < t0 + 2) step();
    drive_cfg();
    step();
    chk("t5_dst_hold", o_dst_addr, old_dst);
    while (cyc < exp_s_cyc[$]) step();
    i_req = '0;
    collect("t5_cfg", d2 + 6);

    cur_blen[3] = 8'd255;
    drive_cfg();
    step();
    run_static("max_burst", 4'b1000, 1, 1'b0);

    for (int i = 0; i < N; i++) cur_blen[i] = 8'd0;
    drive_cfg();
    step();
    t0 = cyc;
    i_req = 4'b0001;
    while (cyc < t0 + 2) step();
    chk("t6_start_pre_rst", o_start, 1);
    do_reset("t6_rst_midframe");
    run_static("t6_len0", 4'b0001, 1, 1'b0);
`ifdef SCHED_STATS_EN
    chk("t6_frame_cnt", o_frame_cnt, 1);
    chk("t6_burst_cnt", o_burst_cnt, 1);
`endif

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        cur_blen[i] = 8'($urandom_range(0, 3));
        cur_fix[i]  = 1'($urandom());
        cur_int[i]  = 8'($urandom());
        cur_dst[i]  = 42'({$urandom(), $urandom()});
        cur_src[i]  = 42'({$urandom(), $urandom()});
        cur_typ[i]  = 16'($urandom());
        cur_opc[i]  = 16'($urandom());
      end
      drive_cfg();
      step();
      run_static($sformatf("rnd%0d", r), 4'($urandom_range(1, 15)), 3, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
